branch_resolver: RTL and testbench

Commit-side control-flow checker for the out-of-order core. It receives each retiring JAL/JALR/branch from the ROB together with the next-PC chosen at fetch time and the next-PC actually computed by execution. On a mismatch it issues a one-cycle redirect to the fetch unit and holds a pipeline-wide flush for a fixed number of cycles, blocking further commits until recovery completes. It is the checking counterpart of the fetch-stage next-PC predictor.

---
 rtl/branch_resolver.sv | 119 +++++++++++
 tb/tb_branch_resolver.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolver.sv
// branch_resolver: commit-side control-flow checker.
// Compares each retiring JAL/JALR/branch's predicted next-PC with its resolved
// next-PC. On a mismatch it pulses redirect_valid for one enabled cycle and
// holds flush_out (blocking commits) for FLUSH_CYCLES enabled cycles.
// Optional feature macro: BRANCH_STATS_EN adds saturating stat_total/stat_miss.
module branch_resolver #(
  parameter int FLUSH_CYCLES = 2
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        cm_valid,
  input  logic [6:0]  cm_opcode,
  input  logic [31:0] cm_pc,
  input  logic [31:0] cm_pred_pc,
  input  logic [31:0] cm_real_pc,
  output logic        cm_ready,
  output logic        flush_out,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc
`ifdef BRANCH_STATS_EN
  ,
  output logic [31:0] stat_total,
  output logic [31:0] stat_miss
`endif
);

  localparam logic       IDLE  = 1'b0;
  localparam logic       FLUSH = 1'b1;

  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

  logic       state_reg;
  logic [3:0] count_reg;
  logic       flush_reg;
  logic       redirect_valid_reg;
  logic [31:0] redirect_pc_reg;

  logic accept;
  logic is_cf;
  logic mispredict;

  // The commit PC only identifies the instruction; the checker needs next-PCs.
  logic unused_pc;
  assign unused_pc = ^cm_pc;

  // Ready depends on state alone so there is no path from cm_* back to the ROB.
  assign cm_ready = (state_reg == IDLE);

  // Decode the commit: accepted, control-flow, and mispredicted (full compare).
  always_comb begin
    is_cf      = (cm_opcode == OP_JAL) || (cm_opcode == OP_JALR) ||
                 (cm_opcode == OP_BRANCH);
    accept     = cm_valid && cm_ready && rdy_in && !rst_in;
    mispredict = accept && is_cf && (cm_pred_pc != cm_real_pc);
  end

  // Recovery FSM: IDLE accepts commits; FLUSH counts down the flush window.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_reg          <= IDLE;
      count_reg          <= 4'd0;
      flush_reg          <= 1'b0;
      redirect_valid_reg <= 1'b0;
      redirect_pc_reg    <= 32'd0;
    end else if (rdy_in) begin
      redirect_valid_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (mispredict) begin
            state_reg          <= FLUSH;
            count_reg          <= FLUSH_LOAD;
            flush_reg          <= 1'b1;
            redirect_valid_reg <= 1'b1;
            redirect_pc_reg    <= {cm_real_pc[31:1], 1'b0};
          end
        end
        default: begin
          if (count_reg == 4'd0) begin
            state_reg <= IDLE;
            flush_reg <= 1'b0;
          end else begin
            count_reg <= count_reg - 4'd1;
          end
        end
      endcase
    end
  end

  assign flush_out      = flush_reg;
  assign redirect_valid = redirect_valid_reg;
  assign redirect_pc    = redirect_pc_reg;

`ifdef BRANCH_STATS_EN
  logic [31:0] stat_total_reg;
  logic [31:0] stat_miss_reg;

  // Saturating counters of accepted control-flow commits and mispredictions.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      stat_total_reg <= 32'd0;
      stat_miss_reg  <= 32'd0;
    end else begin
      if (accept && is_cf && (stat_total_reg != 32'hFFFF_FFFF))
        stat_total_reg <= stat_total_reg + 32'd1;
      if (mispredict && (stat_miss_reg != 32'hFFFF_FFFF))
        stat_miss_reg <= stat_miss_reg + 32'd1;
    end
  end

  assign stat_total = stat_total_reg;
  assign stat_miss  = stat_miss_reg;
`endif

endmodule

// File: tb/tb_branch_resolver.sv
// tb_branch_resolver: table-driven commit vectors with a scoreboard queue,
// plus hand-written sequences for stall, reset-in-flush and saturation.
module tb_branch_resolver;

  localparam int FC = 2;

  localparam logic [6:0] JAL  = 7'b1101111;
  localparam logic [6:0] JALR = 7'b1100111;
  localparam logic [6:0] BR   = 7'b1100011;
  localparam logic [6:0] ALU  = 7'b0110011;
  localparam logic [6:0] LD   = 7'b0000011;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic        cm_valid;
  logic [6:0]  cm_opcode;
  logic [31:0] cm_pc;
  logic [31:0] cm_pred_pc;
  logic [31:0] cm_real_pc;
  logic        cm_ready;
  logic        flush_out;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
`ifdef BRANCH_STATS_EN
  logic [31:0] stat_total;
  logic [31:0] stat_miss;
`endif

  branch_resolver #(.FLUSH_CYCLES(FC)) dut (
    .clk_in(clk_in),
    .rst_in(rst_in),
    .rdy_in(rdy_in),
    .cm_valid(cm_valid),
    .cm_opcode(cm_opcode),
    .cm_pc(cm_pc),
    .cm_pred_pc(cm_pred_pc),
    .cm_real_pc(cm_real_pc),
    .cm_ready(cm_ready),
    .flush_out(flush_out),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc)
`ifdef BRANCH_STATS_EN
    ,
    .stat_total(stat_total),
    .stat_miss(stat_miss)
`endif
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [6:0]  op;
    logic [31:0] pc;
    logic [31:0] pred;
    logic [31:0] real_pc;
    logic        miss;
    logic [31:0] rpc;
  } vec_t;

  typedef struct {
    logic        miss;
    logic [31:0] rpc;
  } exp_t;

  vec_t  vecs[8];
  exp_t  sb[$];
  int    checks = 0;
  int    errors = 0;
  logic [31:0] last_rpc = 32'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [6:0] op, input logic [31:0] pc,
                       input logic [31:0] pred, input logic [31:0] rp);
    cm_valid   = 1'b1;
    cm_opcode  = op;
    cm_pc      = pc;
    cm_pred_pc = pred;
    cm_real_pc = rp;
  endtask

  // Apply one commit at a negedge and verify the recovery window that follows.
  task automatic apply(input vec_t v, input int idx);
    exp_t e;
    drive(v.op, v.pc, v.pred, v.real_pc);
    sb.push_back('{miss: v.miss, rpc: v.rpc});
    @(negedge clk_in);
    e = sb.pop_front();
    if (e.miss) begin
      // Keep presenting a mispredicting commit during flush; it must be dropped.
      drive(JAL, 32'hDEAD_0000, 32'h0000_0040, 32'h0000_0080);
      check("redirect_valid", {31'd0, redirect_valid}, 32'd1);
      check("redirect_pc", redirect_pc, e.rpc);
      check("flush_first", {31'd0, flush_out}, 32'd1);
      check("ready_first", {31'd0, cm_ready}, 32'd0);
      last_rpc = e.rpc;
      for (int k = 1; k < FC; k++) begin
        @(negedge clk_in);
        check("redirect_drop", {31'd0, redirect_valid}, 32'd0);
        check("flush_hold", {31'd0, flush_out}, 32'd1);
        check("ready_hold", {31'd0, cm_ready}, 32'd0);
      end
      @(negedge clk_in);
      cm_valid = 1'b0;
      check("flush_end", {31'd0, flush_out}, 32'd0);
      check("ready_back", {31'd0, cm_ready}, 32'd1);
      check("redirect_idle", {31'd0, redirect_valid}, 32'd0);
    end else begin
      check("no_redirect", {31'd0, redirect_valid}, 32'd0);
      check("no_flush", {31'd0, flush_out}, 32'd0);
      check("ready_stays", {31'd0, cm_ready}, 32'd1);
      check("rpc_holds", redirect_pc, last_rpc);
    end
    $display("vec %0d op=%b pred=%h real=%h miss=%0d rpc=%h", idx, v.op, v.pred,
             v.real_pc, e.miss, redirect_pc);
  endtask

  initial begin
    vecs[0] = '{JAL,  32'h100, 32'h180,  32'h180,      1'b0, 32'h0};
    vecs[1] = '{BR,   32'h200, 32'h204,  32'h300,      1'b1, 32'h300};
    vecs[2] = '{JALR, 32'h300, 32'h1000, 32'h2001,     1'b1, 32'h2000};
    vecs[3] = '{ALU,  32'h304, 32'h10,   32'h20,       1'b0, 32'h0};
    vecs[4] = '{BR,   32'h308, 32'h400,  32'h400,      1'b0, 32'h0};
    vecs[5] = '{JAL,  32'h400, 32'h0,    32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFE};
    vecs[6] = '{LD,   32'h404, 32'h1,    32'h2,        1'b0, 32'h0};
    vecs[7] = '{JALR, 32'h408, 32'h8,    32'h9,        1'b1, 32'h8};

    rst_in = 1'b1; rdy_in = 1'b1; cm_valid = 1'b0;
    cm_opcode = 7'd0; cm_pc = 32'd0; cm_pred_pc = 32'd0; cm_real_pc = 32'd0;
    repeat (3) @(negedge clk_in);
    rst_in = 1'b0;
    check("rst_ready", {31'd0, cm_ready}, 32'd1);
    check("rst_flush", {31'd0, flush_out}, 32'd0);
    check("rst_redirect", {31'd0, redirect_valid}, 32'd0);
    check("rst_rpc", redirect_pc, 32'd0);
`ifdef BRANCH_STATS_EN
    check("rst_total", stat_total, 32'd0);
    check("rst_miss", stat_miss, 32'd0);
`endif

    // Back-to-back table vectors; hits are accepted one per cycle.
    for (int i = 0; i < 8; i++) apply(vecs[i], i);
    cm_valid = 1'b0;
    @(negedge clk_in);
`ifdef BRANCH_STATS_EN
    check("stat_total", stat_total, 32'd6);
    check("stat_miss", stat_miss, 32'd4);
`endif

    // Commit presented with rdy_in low in IDLE is not accepted.
    rdy_in = 1'b0;
    drive(BR, 32'h500, 32'h504, 32'h600);
    @(negedge clk_in);
    cm_valid = 1'b0;
    rdy_in = 1'b1;
    check("stall_noaccept", {31'd0, redirect_valid}, 32'd0);
    check("stall_noflush", {31'd0, flush_out}, 32'd0);
    $display("seq stall_idle redirect_valid=%0d", redirect_valid);

    // Mispredict then rdy_in low for three cycles inside the flush.
    drive(BR, 32'h500, 32'h504, 32'h700);
    @(negedge clk_in);
    cm_valid = 1'b0;
    check("frz_pulse", {31'd0, redirect_valid}, 32'd1);
    check("frz_rpc", redirect_pc, 32'h700);
    rdy_in = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_in);
      check("frz_redirect", {31'd0, redirect_valid}, 32'd1);
      check("frz_flush", {31'd0, flush_out}, 32'd1);
      check("frz_ready", {31'd0, cm_ready}, 32'd0);
    end
    rdy_in = 1'b1;
    @(negedge clk_in);
    check("frz_drop", {31'd0, redirect_valid}, 32'd0);
    check("frz_flush2", {31'd0, flush_out}, 32'd1);
    @(negedge clk_in);
    check("frz_end", {31'd0, flush_out}, 32'd0);
    check("frz_ready_back", {31'd0, cm_ready}, 32'd1);
    $display("seq stall_flush flush_out=%0d cm_ready=%0d", flush_out, cm_ready);

    // Reset in the middle of a flush aborts it; the reset-cycle commit is dropped.
    drive(JAL, 32'h800, 32'h804, 32'h900);
    @(negedge clk_in);
    check("rf_flush", {31'd0, flush_out}, 32'd1);
    rst_in = 1'b1;
    @(negedge clk_in);
    check("rf_flush_off", {31'd0, flush_out}, 32'd0);
    check("rf_ready", {31'd0, cm_ready}, 32'd1);
    check("rf_rpc", redirect_pc, 32'd0);
    @(negedge clk_in);
    check("rf_noaccept", {31'd0, redirect_valid}, 32'd0);
`ifdef BRANCH_STATS_EN
    check("rf_total", stat_total, 32'd0);
    check("rf_miss", stat_miss, 32'd0);
`endif
    cm_valid = 1'b0;
    rst_in = 1'b0;
    $display("seq reset_flush flush_out=%0d cm_ready=%0d", flush_out, cm_ready);

`ifdef BRANCH_STATS_EN
    // Saturation of the miss counter.
    force dut.stat_miss_reg = 32'hFFFF_FFFF;
    @(negedge clk_in);
    release dut.stat_miss_reg;
    drive(BR, 32'hA00, 32'hA04, 32'hB00);
    @(negedge clk_in);
    cm_valid = 1'b0;
    check("sat_redirect", {31'd0, redirect_valid}, 32'd1);
    check("sat_miss", stat_miss, 32'hFFFF_FFFF);
    check("sat_total", stat_total, 32'd1);
    $display("seq saturate stat_miss=%h", stat_miss);
    repeat (FC + 1) @(negedge clk_in);
`endif

    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard: got %0d leftover expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
